// File: rtl/nbit_updown_counter.sv
// nbit_updown_counter
// Up/down counter over the range 0..MAX_COUNT with parallel load (clamped to
// the range), selectable wrap or saturate at the range ends, a combinational
// terminal-count flag, a one-cycle wrap pulse and a saturation-hold flag.
// clr is an asynchronous, active-low reset.

module nbit_updown_counter #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             mode,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             busy_sat
);

  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic             ovf_r;
  logic             busy_sat_r;

  logic [WIDTH-1:0] q_next_s;
  logic             ovf_next_s;
  logic             busy_next_s;
  logic [WIDTH-1:0] load_val_s;
  logic             at_top_s;
  logic             at_bot_s;

  // Range-end detection and the clamped load value; q never leaves 0..MAX_COUNT.
  assign at_top_s   = (q_r == MAX_COUNT);
  assign at_bot_s   = (q_r == ZERO_V);
  assign load_val_s = (d > MAX_COUNT) ? MAX_COUNT : d;

  // Next-state decode with priority load > enable > hold.
  always_comb begin
    q_next_s    = q_r;
    ovf_next_s  = 1'b0;
    busy_next_s = 1'b0;
    if (load) begin
      // Load always wins, clears the wrap pulse and the saturation flag.
      q_next_s = load_val_s;
    end else if (en) begin
      if (mode == 1'b0) begin
        if (at_top_s) begin
          if (sat) begin
            busy_next_s = 1'b1;
          end else begin
            q_next_s   = ZERO_V;
            ovf_next_s = 1'b1;
          end
        end else begin
          q_next_s = q_r + ONE_V;
        end
      end else begin
        if (at_bot_s) begin
          if (sat) begin
            busy_next_s = 1'b1;
          end else begin
            q_next_s   = MAX_COUNT;
            ovf_next_s = 1'b1;
          end
        end else begin
          q_next_s = q_r - ONE_V;
        end
      end
    end else begin
      // Disabled: hold the count; pulse and saturation flag drop.
      q_next_s = q_r;
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_r        <= ZERO_V;
      ovf_r      <= 1'b0;
      busy_sat_r <= 1'b0;
    end else begin
      q_r        <= q_next_s;
      ovf_r      <= ovf_next_s;
      busy_sat_r <= busy_next_s;
    end
  end

  // Terminal count follows the current direction, independent of enable.
  assign tc       = mode ? at_bot_s : at_top_s;
  assign q        = q_r;
  assign ovf      = ovf_r;
  assign busy_sat = busy_sat_r;

endmodule

// File: tb/tb_nbit_updown_counter.sv
// Testbench for nbit_updown_counter: one instance with WIDTH=4, MAX_COUNT=9
// and one with default parameters, both driven by the same inputs and
// compared every cycle against an arithmetic reference model.

module tb_nbit_updown_counter;

  logic       clk = 1'b0;
  logic       clr, en, mode, sat, load;
  logic [3:0] d;
  logic [3:0] qa, qb;
  logic       tca, tcb, ovfa, ovfb, busya, busyb;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state for each instance.
  int mqa, mqb;
  bit moa, mba, mob, mbb;

  int exp030 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp031 [5]  = '{2, 1, 0, 9, 8};

  nbit_updown_counter #(.WIDTH(4), .MAX_COUNT(4'd9)) dut_a (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .sat(sat), .load(load),
    .d(d), .q(qa), .tc(tca), .ovf(ovfa), .busy_sat(busya)
  );

  nbit_updown_counter dut_b (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .sat(sat), .load(load),
    .d(d), .q(qb), .tc(tcb), .ovf(ovfb), .busy_sat(busyb)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  // Count modulo mx+1 from the counting rules; saturate holds at the end.
  function automatic void model_step(input int mx, input bit ld, input bit e,
                                     input bit md, input bit st, input int dv,
                                     inout int mq, inout bit mo, inout bit mb);
    int n;
    if (ld) begin
      mq = (dv > mx) ? mx : dv;
      mo = 1'b0;
      mb = 1'b0;
    end else if (e) begin
      n = md ? mq - 1 : mq + 1;
      if (n < 0 || n > mx) begin
        if (st) begin
          mo = 1'b0;
          mb = 1'b1;
        end else begin
          mq = (n + mx + 1) % (mx + 1);
          mo = 1'b1;
          mb = 1'b0;
        end
      end else begin
        mq = n;
        mo = 1'b0;
        mb = 1'b0;
      end
    end else begin
      mo = 1'b0;
      mb = 1'b0;
    end
  endfunction

  task automatic model_reset();
    mqa = 0; moa = 1'b0; mba = 1'b0;
    mqb = 0; mob = 1'b0; mbb = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_a_q"},    int'(qa),    mqa);
    chk({tag, "_a_ovf"},  int'(ovfa),  int'(moa));
    chk({tag, "_a_busy"}, int'(busya), int'(mba));
    chk({tag, "_a_tc"},   int'(tca),   mode ? int'(mqa == 0) : int'(mqa == 9));
    chk({tag, "_b_q"},    int'(qb),    mqb);
    chk({tag, "_b_ovf"},  int'(ovfb),  int'(mob));
    chk({tag, "_b_busy"}, int'(busyb), int'(mbb));
    chk({tag, "_b_tc"},   int'(tcb),   mode ? int'(mqb == 0) : int'(mqb == 15));
  endtask

  // One clock edge: update the model from the sampled inputs, check on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (clr) begin
      model_step(9,  load, en, mode, sat, int'(d), mqa, moa, mba);
      model_step(15, load, en, mode, sat, int'(d), mqb, mob, mbb);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous clear pulse placed between clock edges (called just after a falling edge).
  task automatic pulse_clr(input string tag);
    #2 clr = 1'b0;
    model_reset();
    #1 check_all(tag);
    #1 clr = 1'b1;
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; mode = 1'b0; sat = 1'b0; load = 1'b0; d = 4'd0;
    model_reset();

    // Reset state, tc follows mode during reset.
    #2 check_all("rst_up");
    mode = 1'b1;
    #1 check_all("rst_dn");
    mode = 1'b0;
    @(negedge clk);

    // Up-count with wrap through 9 -> 0.
    clr = 1'b1; en = 1'b1; mode = 1'b0; sat = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step("up");
      chk("up_seq", int'(qa), exp030[i]);
    end

    // Load 3 then count down through 0 -> 9.
    load = 1'b1; d = 4'd3;
    step("ld3");
    chk("ld3_q", int'(qa), 3);
    load = 1'b0; mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("dn");
      chk("dn_seq", int'(qa), exp031[i]);
    end

    // Saturate at the top, then reverse direction.
    load = 1'b1; d = 4'd8; mode = 1'b0; sat = 1'b1;
    step("ld8");
    load = 1'b0;
    for (int i = 0; i < 3; i++) step("sat");
    chk("sat_busy", int'(busya), 1);
    mode = 1'b1;
    step("sat_rev");
    chk("sat_rev_q", int'(qa), 8);

    // Clamped load, then load overriding a pending wrap.
    load = 1'b1; d = 4'd14; sat = 1'b0; mode = 1'b0;
    step("clamp");
    chk("clamp_q", int'(qa), 9);
    d = 4'd5;
    step("ld_wrap");
    chk("ld_wrap_ovf", int'(ovfa), 0);

    // Mid-count asynchronous clear at q=6, resume to 1.
    load = 1'b0;
    step("to6");
    pulse_clr("mid_clr");
    step("after_clr");
    chk("after_clr_q", int'(qa), 1);

    // Default instance: full wrap 15 -> 0, then hold with en=0.
    load = 1'b1; d = 4'd14;
    step("b_ld14");
    load = 1'b0;
    step("b_15");
    step("b_wrap");
    chk("b_wrap_ovf", int'(ovfb), 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("hold");
    chk("hold_q", int'(qb), 0);

    // Randomized traffic with occasional asynchronous clears.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 1) == 1;
      sat  = $urandom_range(0, 1) == 1;
      load = ($urandom_range(0, 9) == 0);
      d    = 4'($urandom_range(0, 15));
      step("rnd");
      if ($urandom_range(0, 39) == 0) pulse_clr("rnd_clr");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nbit_updown_counter.md
NBIT_UPDOWN_COUNTER -- requirements
Module: nbit_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter MAX_COUNT, default 2**WIDTH-1, terminal value of the count range 0..MAX_COUNT (legal range 1..2**WIDTH-1).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port clr, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port mode, input, 1 bit: count direction; 0 = up, 1 = down.
REQ-007 SHALL have port sat, input, 1 bit: range-end behaviour; 0 = wrap, 1 = saturate.
REQ-008 SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-009 SHALL have port d, input, WIDTH bits: parallel load value.
REQ-010 SHALL have port q, output, WIDTH bits: registered count.
REQ-011 SHALL have port tc, output, 1 bit: combinational terminal-count flag.
REQ-012 SHALL have port ovf, output, 1 bit: registered one-cycle wrap pulse.
REQ-013 SHALL have port busy_sat, output, 1 bit: registered flag, high while the counter is held at a range end by saturation.

Function
REQ-014 SHALL apply per-edge priority: clr low > load > en > hold.
REQ-015 SHALL, on load=1, set q to d when d <= MAX_COUNT, else to MAX_COUNT (clamp), regardless of en, mode and sat.
REQ-016 SHALL, with en=1, load=0, mode=0 and q < MAX_COUNT, set q to q+1 on the next edge.
REQ-017 SHALL, with en=1, load=0, mode=1 and q > 0, set q to q-1 on the next edge.
REQ-018 SHALL, when counting up at q=MAX_COUNT with sat=0, set q to 0 and assert ovf for exactly the following cycle.
REQ-019 SHALL, when counting down at q=0 with sat=0, set q to MAX_COUNT and assert ovf for exactly the following cycle.
REQ-020 SHALL, when counting up at q=MAX_COUNT or down at q=0 with sat=1, hold q, keep ovf at 0 and set busy_sat to 1.
REQ-021 SHALL clear busy_sat on any edge where q changes value, on load, or when en=0.
REQ-022 SHALL hold q and drive ovf=0 on any edge with en=0 and load=0.
REQ-023 SHALL assert tc=1 when (mode=0 and q=MAX_COUNT) or (mode=1 and q=0), else tc=0, independent of en.
REQ-024 SHALL apply mode and sat changes on the first edge at which they are sampled, with no pipeline delay.
REQ-025 SHALL deassert ovf on any edge where load=1, even if the prior count would have wrapped.
REQ-026 SHALL perform all arithmetic modulo MAX_COUNT+1 and never present a q value greater than MAX_COUNT.

Reset
REQ-027 SHALL, while clr=0, force q=0, ovf=0 and busy_sat=0 immediately, independent of clk.
REQ-028 SHALL resume counting on the first rising clk edge after clr returns high; a mid-count reset discards the count.
REQ-029 SHALL drive tc=1 during reset when mode=1 (q=0), else tc=0.

Verification (WIDTH=4, MAX_COUNT=9 unless stated)
REQ-030 SHALL cover: clr pulse, then en=1, mode=0, sat=0 for 12 edges -> q=1..9,0,1,2; ovf high only the cycle after 9->0; tc high only while q=9.
REQ-031 SHALL cover: load d=3, then mode=1, sat=0 for 5 edges -> q=3,2,1,0,9,8; ovf pulses once after 0->9.
REQ-032 SHALL cover: sat=1, mode=0 starting at q=8 -> q=9,9,9; ovf stays 0; busy_sat=1 from the second 9; mode flipped to 1 -> q=8 and busy_sat=0.
REQ-033 SHALL cover: load d=14 -> q=9 (clamp); load asserted with en=1 at q=9, sat=0 -> q=d, ovf=0.
REQ-034 SHALL cover: clr driven low between clock edges at q=6 -> q=0 immediately; the first edge after release with en=1, mode=0 -> q=1.
REQ-035 SHALL cover: defaults WIDTH=4, MAX_COUNT=15, full up-wrap 15->0 with ovf pulse, and en=0 held for 3 edges -> q unchanged.
